// File: rtl/downsampler_v_window_ctrl.sv
// downsampler_v_window_ctrl
//   Stream sequencer for a vertical 2:1 fp16 downsampler. Each even row is held in
//   a single-line buffer. On the following odd row, the stored pixel and the live
//   pixel are presented as a 2x1 window with the row coordinate halved. The kernel
//   output is the constant [0.5; 0.5].
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   data_i       input pixel (fp)
//   col_i/row_i  input pixel coordinates
//   valid_i      input pixel qualifier (no backpressure)
//   clear_err_i  synchronous clear of err_o (a set in the same cycle wins)
//   window_o     [0][0] = even-row pixel, [1][0] = odd-row pixel
//   kernel_o     constant 0.5 in both taps
//   col_o/row_o  output coordinates (row_o = odd input row >> 1)
//   valid_o      window qualifier
//   err_o        sticky pairing/range error
module downsampler_v_window_ctrl #(
    parameter int unsigned EXP_WIDTH    = 5,
    parameter int unsigned FRAC_WIDTH   = 10,
    parameter int unsigned MAX_WIDTH    = 1024,
    localparam int unsigned FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [FP_WIDTH_REG-1:0]             data_i,
    input  logic [15:0]                         col_i,
    input  logic [15:0]                         row_i,
    input  logic                                valid_i,
    input  logic                                clear_err_i,
    output logic [1:0][0:0][FP_WIDTH_REG-1:0]   window_o,
    output logic [1:0][0:0][FP_WIDTH_REG-1:0]   kernel_o,
    output logic [15:0]                         col_o,
    output logic [15:0]                         row_o,
    output logic                                valid_o,
    output logic                                err_o
);

    localparam int unsigned AddrW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    // 0.5 = sign 0, exponent bias-1, fraction 0
    localparam logic [EXP_WIDTH-1:0] KExp = EXP_WIDTH'((1 << (EXP_WIDTH - 1)) - 2);
    localparam logic [FP_WIDTH_REG-1:0] KHalf = {1'b0, KExp, {FRAC_WIDTH{1'b0}}};

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StEmit = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [15:0]             pair_row_q, pair_row_d;
    logic                    err_q, err_d;
    logic                    valid_q;
    logic [FP_WIDTH_REG-1:0] win_even_q, win_odd_q;
    logic [15:0]             col_q, row_q;

    logic [FP_WIDTH_REG-1:0] line_mem_q [MAX_WIDTH];

    logic             col_ok;
    logic [AddrW-1:0] addr;
    logic [15:0]      pair_next;
    logic             wr_en, emit, err_set;

    assign col_ok    = (32'(col_i) < MAX_WIDTH);
    assign addr      = col_i[AddrW-1:0];
    assign pair_next = pair_row_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        pair_row_d = pair_row_q;
        wr_en      = 1'b0;
        emit       = 1'b0;
        err_set    = 1'b0;
        if (valid_i) begin
            if (!col_ok) begin
                // Out-of-range column: drop, flag, keep state.
                err_set = 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (!row_i[0]) begin
                            wr_en      = 1'b1;
                            pair_row_d = row_i;
                            state_d    = StFill;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                    StFill: begin
                        if (!row_i[0]) begin
                            wr_en = 1'b1;
                            if (row_i != pair_row_q) begin
                                // New even row before its odd partner: restart pairing.
                                pair_row_d = row_i;
                                err_set    = 1'b1;
                            end
                        end else if (row_i == pair_next) begin
                            emit    = 1'b1;
                            state_d = StEmit;
                        end else begin
                            err_set = 1'b1;
                            state_d = StIdle;
                        end
                    end
                    StEmit: begin
                        if (!row_i[0]) begin
                            wr_en      = 1'b1;
                            pair_row_d = row_i;
                            state_d    = StFill;
                        end else if (row_i == pair_next) begin
                            emit = 1'b1;
                        end else begin
                            err_set = 1'b1;
                            state_d = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end

        err_d = err_q;
        if (clear_err_i) err_d = 1'b0;
        if (err_set)     err_d = 1'b1;
    end

    // Line buffer: contents are not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) line_mem_q[addr] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            pair_row_q <= 16'd0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            win_even_q <= '0;
            win_odd_q  <= '0;
            col_q      <= 16'd0;
            row_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            pair_row_q <= pair_row_d;
            err_q      <= err_d;
            valid_q    <= emit;
            // Window fields hold their last emitted values between emits.
            if (emit) begin
                win_even_q <= line_mem_q[addr];
                win_odd_q  <= data_i;
                col_q      <= col_i;
                row_q      <= row_i >> 1;
            end
        end
    end

    assign window_o[0][0] = win_even_q;
    assign window_o[1][0] = win_odd_q;
    assign kernel_o[0][0] = KHalf;
    assign kernel_o[1][0] = KHalf;
    assign col_o          = col_q;
    assign row_o          = row_q;
    assign valid_o        = valid_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_downsampler_v_window_ctrl.sv
module tb_downsampler_v_window_ctrl;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [15:0]            data_i;
    logic [15:0]            col_i;
    logic [15:0]            row_i;
    logic                   valid_i;
    logic                   clear_err_i;
    logic [1:0][0:0][15:0]  window_o;
    logic [1:0][0:0][15:0]  kernel_o;
    logic [15:0]            col_o;
    logic [15:0]            row_o;
    logic                   valid_o;
    logic                   err_o;

    int errors = 0;
    int checks = 0;

    downsampler_v_window_ctrl #(
        .EXP_WIDTH  (5),
        .FRAC_WIDTH (10),
        .MAX_WIDTH  (1024)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .col_i       (col_i),
        .row_i       (row_i),
        .valid_i     (valid_i),
        .clear_err_i (clear_err_i),
        .window_o    (window_o),
        .kernel_o    (kernel_o),
        .col_o       (col_o),
        .row_o       (row_o),
        .valid_o     (valid_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pix(input logic [15:0] r, input logic [15:0] c, input logic [15:0] d);
        valid_i = 1'b1;
        row_i   = r;
        col_i   = c;
        data_i  = d;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic expect_emit(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] c, input logic [15:0] r);
        check({tag, ".valid"}, valid_o, 1'b1);
        check({tag, ".w0"}, window_o[0][0], w0);
        check({tag, ".w1"}, window_o[1][0], w1);
        check({tag, ".col"}, col_o, c);
        check({tag, ".row"}, row_o, r);
    endtask

    task automatic clear_err();
        clear_err_i = 1'b1;
        tick();
        clear_err_i = 1'b0;
    endtask

    function automatic logic [15:0] dat(input int r, input int c);
        return 16'(16'h1000 + r * 16 + c);
    endfunction

    logic [15:0] basic_even [4];

    initial begin
        basic_even[0] = 16'h3C00;
        basic_even[1] = 16'h4000;
        basic_even[2] = 16'h4200;
        basic_even[3] = 16'h4400;

        rst_i = 1'b0; valid_i = 1'b0; clear_err_i = 1'b0;
        data_i = '0; col_i = '0; row_i = '0;
        tick();
        tick();
        // Reset state
        check("rst.valid", valid_o, 1'b0);
        check("rst.err", err_o, 1'b0);
        check("rst.col", col_o, 16'h0);
        check("rst.row", row_o, 16'h0);
        check("rst.w0", window_o[0][0], 16'h0);
        check("rst.w1", window_o[1][0], 16'h0);
        check("rst.k0", kernel_o[0][0], 16'h3800);
        check("rst.k1", kernel_o[1][0], 16'h3800);
        rst_i = 1'b1;
        tick();

        // Basic pair
        for (int c = 0; c < 4; c++) begin
            pix(16'd0, 16'(c), basic_even[c]);
            check("basic.even.valid", valid_o, 1'b0);
        end
        for (int c = 0; c < 4; c++) begin
            pix(16'd1, 16'(c), 16'h0000);
            expect_emit("basic", basic_even[c], 16'h0000, 16'(c), 16'd0);
            check("basic.k0", kernel_o[0][0], 16'h3800);
            check("basic.k1", kernel_o[1][0], 16'h3800);
        end
        check("basic.err", err_o, 1'b0);
        tick();
        check("hold.valid", valid_o, 1'b0);
        check("hold.w0", window_o[0][0], 16'h4400);
        check("hold.col", col_o, 16'd3);

        // Multi-pair back-to-back, rows 2..5 width 8
        for (int r = 2; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                pix(16'(r), 16'(c), dat(r, c));
                if (r % 2 == 1) expect_emit("multi", dat(r - 1, c), dat(r, c), 16'(c), 16'(r / 2));
                else check("multi.even.valid", valid_o, 1'b0);
            end
        end
        check("multi.err", err_o, 1'b0);

        // Missing odd row: row 6 then row 8
        for (int c = 0; c < 4; c++) begin
            pix(16'd6, 16'(c), dat(6, c));
            check("miss.r6.valid", valid_o, 1'b0);
        end
        check("miss.r6.err", err_o, 1'b0);
        for (int c = 0; c < 4; c++) begin
            pix(16'd8, 16'(c), dat(8, c));
            check("miss.r8.valid", valid_o, 1'b0);
            check("miss.r8.err", err_o, 1'b1);
        end
        for (int c = 0; c < 4; c++) begin
            pix(16'd9, 16'(c), dat(9, c));
            expect_emit("miss.r9", dat(8, c), dat(9, c), 16'(c), 16'd4);
        end
        clear_err();
        check("miss.clear", err_o, 1'b0);

        // Orphan odd row after reset
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        pix(16'd1, 16'd0, 16'h1234);
        check("orphan.valid", valid_o, 1'b0);
        check("orphan.err", err_o, 1'b1);
        clear_err();
        check("orphan.clear", err_o, 1'b0);

        // Range: col == MAX_WIDTH dropped
        pix(16'd10, 16'd1024, 16'hDEAD);
        check("range.valid", valid_o, 1'b0);
        check("range.err", err_o, 1'b1);
        clear_err();
        check("range.clear", err_o, 1'b0);
        pix(16'd10, 16'd0, 16'hA000);
        pix(16'd10, 16'd1023, 16'hA3FF);
        pix(16'd11, 16'd0, 16'hB000);
        expect_emit("range.c0", 16'hA000, 16'hB000, 16'd0, 16'd5);
        pix(16'd11, 16'd1023, 16'hB3FF);
        expect_emit("range.c1023", 16'hA3FF, 16'hB3FF, 16'd1023, 16'd5);
        check("range.err2", err_o, 1'b0);

        // Even write at N, odd read of same column at N+1
        pix(16'd12, 16'd5, 16'hC005);
        check("b2b.even.valid", valid_o, 1'b0);
        pix(16'd13, 16'd5, 16'hD005);
        expect_emit("b2b", 16'hC005, 16'hD005, 16'd5, 16'd6);
        tick();
        check("b2b.hold.valid", valid_o, 1'b0);
        check("b2b.hold.w0", window_o[0][0], 16'hC005);
        check("b2b.hold.row", row_o, 16'd6);

        // Reset mid-EMIT with err_o set beforehand
        pix(16'd3, 16'd0, 16'h0);
        check("pre.err", err_o, 1'b1);
        for (int c = 0; c < 4; c++) pix(16'd0, 16'(c), dat(0, c));
        for (int c = 0; c < 2; c++) begin
            pix(16'd1, 16'(c), dat(1, c));
            expect_emit("mid", dat(0, c), dat(1, c), 16'(c), 16'd0);
        end
        #2;
        rst_i = 1'b0;
        #1;
        check("midrst.valid", valid_o, 1'b0);
        check("midrst.err", err_o, 1'b0);
        check("midrst.w0", window_o[0][0], 16'h0);
        tick();
        rst_i = 1'b1;
        pix(16'd1, 16'd3, dat(1, 3));
        check("postrst.valid", valid_o, 1'b0);
        check("postrst.err", err_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/downsampler_v_window_ctrl.md
# downsampler_v_window_ctrl

Stream sequencer that drives the vertical 2:1 fp16 downsampler convolution (2-tall, 1-wide window, kernel [0.5; 0.5]). It accepts a raster pixel stream and buffers each even row in a single-line memory. On the following odd row it presents the stored pixel and the live pixel as a 2x1 window with halved row coordinate, so the convolution emits one output row per input row pair. It also drives the constant kernel and tracks row-pairing errors.

## Interface
- EXP_WIDTH, 5: fp exponent width.
- FRAC_WIDTH, 10: fp fraction width.
- MAX_WIDTH, 1024: line buffer depth (max columns per row).
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH: pixel word width (local).

- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- data_i  in  FP_WIDTH_REG  input pixel.
- col_i  in  16  input column.
- row_i  in  16  input row.
- valid_i  in  1  input pixel qualifier; no backpressure.
- clear_err_i  in  1  synchronous clear of err_o.
- window_o  out  FP_WIDTH_REG [2][1]  [0][0] = even-row pixel, [1][0] = odd-row pixel.
- kernel_o  out  FP_WIDTH_REG [2][1]  both entries constant 0.5.
- col_o  out  16  output column (= input col).
- row_o  out  16  output row (= odd input row >> 1).
- valid_o  out  1  window qualifier, to convolution valid_i.
- err_o  out  1  sticky pairing/range error.

## Operation
- Kernel constant: sign 0, exponent 2^(EXP_WIDTH-1)-2, fraction 0 (16'h3800 at defaults); combinational, independent of reset.
- Line buffer: MAX_WIDTH x FP_WIDTH_REG, synchronous write, synchronous read; contents not reset. Written only on even rows, read only on odd rows, so no same-address read/write collision.
- FSM states IDLE, FILL, EMIT; register pair_row (16b) holds the even row number currently stored.
- Range check (any state): valid_i with col_i >= MAX_WIDTH -> pixel dropped, err_o set, state unchanged.
- IDLE: even pixel -> write buf[col_i], pair_row=row_i, go FILL. Odd pixel -> drop, set err_o, stay IDLE.
- FILL: even pixel with row_i==pair_row -> write. Even pixel with row_i!=pair_row -> restart: write, pair_row=row_i, set err_o (odd row missing). Odd pixel with row_i==pair_row+1 -> read buf[col_i], emit, go EMIT. Other odd -> drop, set err_o, go IDLE.
- EMIT: odd pixel with row_i==pair_row+1 -> emit. Even pixel -> write, pair_row=row_i, go FILL (no error). Other odd -> drop, set err_o, go IDLE.
- Emit: window_o[0][0]=buf[col_i], window_o[1][0]=data_i (delayed 1 cycle), col_o=col_i, row_o=row_i>>1, valid_o=1.
- Odd-height frame: trailing even row stays in FILL, produces no output and raises no error until next pixel.
- Column within a row is not checked for monotonicity; an odd-row column never written in the pair reads stale buffer data (no error).
- err_o: set has priority over clear_err_i in the same cycle.

## Timing
- Reset (rst_i low, async): state IDLE, pair_row=0, valid_o=0, window_o/col_o/row_o=0, err_o=0. Pixel in flight when reset asserts is lost.
- Latency: accepted odd pixel at edge N -> valid_o high cycle N+1; all output fields registered together.
- Throughput: one pixel per cycle, back-to-back rows with no gap between even and odd rows.
- valid_o low on any cycle without an emitting input; window/col/row hold last emitted values when valid_o=0.
- Last even-row pixel at cycle N and first odd-row pixel at N+1 for same column: correct (write at N completes before read at N+1).

## Test plan
- Reset mid-EMIT: stream rows 0,1 (width 4), assert rst_i low during row 1 col 2 -> valid_o, err_o drop to 0 immediately; next odd pixel after release sets err_o.
- Basic pair: row 0 cols 0-3 = 1.0,2.0,3.0,4.0 (3C00,4000,4200,4400), row 1 = 0x0000 x4 -> four valid_o pulses, window_o[0][0]=3C00,4000,4200,4400, row_o=0, col_o=0..3, kernel_o=3800 each.
- Multi-pair back-to-back: 4 rows width 8, no gaps -> 16 outputs, rows 0 then 1, no idle cycle, err_o=0.
- Missing odd row: row 0 then row 2 -> no output, err_o=1; row 3 then emits with window_o[0][0] from row 2.
- Orphan odd row: after reset feed row 1 -> no valid_o, err_o=1; clear_err_i pulse -> err_o=0.
- Range: col_i=MAX_WIDTH on even row -> dropped, err_o=1, subsequent in-range pair outputs unaffected.
